// File: rtl/muldiv_pkg.sv
// Shared definitions for the sequential RV M-extension unit.
// funct3 encodings, FSM states and decode helpers.
package muldiv_pkg;

    localparam logic [2:0] F3_MUL    = 3'd0;
    localparam logic [2:0] F3_MULH   = 3'd1;
    localparam logic [2:0] F3_MULHSU = 3'd2;
    localparam logic [2:0] F3_MULHU  = 3'd3;
    localparam logic [2:0] F3_DIV    = 3'd4;
    localparam logic [2:0] F3_DIVU   = 3'd5;
    localparam logic [2:0] F3_REM    = 3'd6;
    localparam logic [2:0] F3_REMU   = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_t;

    function automatic logic is_signed_div(input logic [2:0] f3);
        return (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/div_restoring_core.sv
// Unsigned restoring divider, one quotient bit per cycle.
// Runs XLEN steps after start_i; done_o marks the final step.
module div_restoring_core #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic            done_o,
    output logic [XLEN-1:0] quotient_o,
    output logic [XLEN-1:0] remainder_o
);

    localparam int CW = $clog2(XLEN) + 1;

    logic [CW-1:0]   cnt_q;
    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] dvs_q;
    logic [XLEN:0]   sh;
    logic [XLEN:0]   diff;

    always_comb begin
        sh   = {rem_q, quo_q[XLEN-1]};
        diff = sh - {1'b0, dvs_q};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            quo_q <= '0;
            rem_q <= '0;
            dvs_q <= '0;
        end else if (start_i) begin
            cnt_q <= CW'(XLEN);
            quo_q <= dividend_i;
            rem_q <= '0;
            dvs_q <= divisor_i;
        end else if (cnt_q != '0) begin
            // A clear top bit means the trial subtraction did not borrow.
            if (!diff[XLEN]) begin
                rem_q <= diff[XLEN-1:0];
                quo_q <= {quo_q[XLEN-2:0], 1'b1};
            end else begin
                rem_q <= sh[XLEN-1:0];
                quo_q <= {quo_q[XLEN-2:0], 1'b0};
            end
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign done_o      = (cnt_q == CW'(1));
    assign quotient_o  = quo_q;
    assign remainder_o = rem_q;

endmodule

// File: rtl/exe_muldiv_seq.sv
// Handshaked sequential multiply/divide unit for the EXE stage.
// Early-outs for div-by-zero, overflow and quotient/remainder cache hits.
module exe_muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int MUL_STEP = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] op1_i,
    input  logic [XLEN-1:0] op2_i,
    input  logic [4:0]      rd_i,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      rd_o,
    output logic            we_o,
    output logic            stall_o
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [CW-1:0] MUL_CNT = CW'(XLEN / MUL_STEP);
    localparam int AW = XLEN + MUL_STEP;

    state_t state_q, state_d;

    logic [CW-1:0]     cnt_q;
    logic [2:0]        f3_q;
    logic [4:0]        rd_q;
    logic              neg_q, rneg_q, early_q, from_div_q;
    logic [XLEN-1:0]   early_res_q, mcand_q, op1_q, op2_q;
    logic [2*XLEN-1:0] prod_q;

    logic              c_vld_q, c_sgn_q;
    logic [XLEN-1:0]   c_op1_q, c_op2_q, c_quo_q, c_rem_q;

    logic              valid_q;
    logic [XLEN-1:0]   result_q;
    logic [4:0]        rd_out_q;

    logic              sg1, sg2, n1, n2, sdiv, mul_op;
    logic              div0, ovf, hit, fast, accept, div_done;
    logic [XLEN-1:0]   mag1, mag2, fast_res;
    logic [AW-1:0]     acc;
    logic [2*XLEN-1:0] prod_nx, pfix;
    logic [XLEN-1:0]   quo, rem, qfix, rfix, done_res;

    // Request decode: operand signedness and early-out detection.
    always_comb begin
        sg1 = 1'b0;
        sg2 = 1'b0;
        unique case (funct3_i)
            F3_MUL:    begin sg1 = 1'b0; sg2 = 1'b0; end
            F3_MULH:   begin sg1 = 1'b1; sg2 = 1'b1; end
            F3_MULHSU: begin sg1 = 1'b1; sg2 = 1'b0; end
            F3_MULHU:  begin sg1 = 1'b0; sg2 = 1'b0; end
            F3_DIV:    begin sg1 = 1'b1; sg2 = 1'b1; end
            F3_DIVU:   begin sg1 = 1'b0; sg2 = 1'b0; end
            F3_REM:    begin sg1 = 1'b1; sg2 = 1'b1; end
            F3_REMU:   begin sg1 = 1'b0; sg2 = 1'b0; end
        endcase
        n1     = sg1 & op1_i[XLEN-1];
        n2     = sg2 & op2_i[XLEN-1];
        mag1   = n1 ? -op1_i : op1_i;
        mag2   = n2 ? -op2_i : op2_i;
        sdiv   = is_signed_div(funct3_i);
        mul_op = ~funct3_i[2];
        div0   = (op2_i == '0);
        ovf    = sdiv && (op1_i == {1'b1, {(XLEN-1){1'b0}}})
                      && (op2_i == '1);
        hit    = c_vld_q && (c_sgn_q == sdiv)
                         && (c_op1_q == op1_i) && (c_op2_q == op2_i);
        fast   = ~mul_op & (div0 | ovf | hit);
        if (div0)
            fast_res = funct3_i[1] ? op1_i : '1;
        else if (ovf)
            fast_res = funct3_i[1] ? '0 : op1_i;
        else
            fast_res = funct3_i[1] ? c_rem_q : c_quo_q;
        accept = valid_i & ready_o & ~flush_i;
    end

    // MUL_STEP partial products added into the top half, then shift right.
    always_comb begin
        acc = AW'(prod_q[2*XLEN-1:XLEN]);
        for (int k = 0; k < MUL_STEP; k++) begin
            if (prod_q[k])
                acc = acc + (AW'(mcand_q) << k);
        end
        prod_nx = {acc, prod_q[XLEN-1:MUL_STEP]};
    end

    div_restoring_core #(
        .XLEN(XLEN)
    ) u_div (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .start_i    (accept & ~mul_op & ~fast),
        .dividend_i (mag1),
        .divisor_i  (mag2),
        .done_o     (div_done),
        .quotient_o (quo),
        .remainder_o(rem)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE:
                    if (valid_i)
                        state_d = mul_op ? S_MUL : (fast ? S_DONE : S_DIV);
                S_MUL:
                    if (cnt_q == CW'(1))
                        state_d = S_DONE;
                S_DIV:
                    if (div_done)
                        state_d = S_DONE;
                S_DONE:
                    state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        ready_o = (state_q == S_IDLE);
        stall_o = ~ready_o | (valid_i & ready_o);
        valid_o = valid_q & ~flush_i;
        we_o    = valid_o & (rd_out_q != 5'd0);
        pfix    = neg_q ? -prod_q : prod_q;
        qfix    = neg_q ? -quo : quo;
        rfix    = rneg_q ? -rem : rem;
        if (early_q)
            done_res = early_res_q;
        else if (f3_q == F3_MUL)
            done_res = pfix[XLEN-1:0];
        else if (!f3_q[2])
            done_res = pfix[2*XLEN-1:XLEN];
        else
            done_res = f3_q[1] ? rfix : qfix;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q       <= '0;
            f3_q        <= '0;
            rd_q        <= '0;
            neg_q       <= 1'b0;
            rneg_q      <= 1'b0;
            early_q     <= 1'b0;
            from_div_q  <= 1'b0;
            early_res_q <= '0;
            mcand_q     <= '0;
            op1_q       <= '0;
            op2_q       <= '0;
            prod_q      <= '0;
            c_vld_q     <= 1'b0;
            c_sgn_q     <= 1'b0;
            c_op1_q     <= '0;
            c_op2_q     <= '0;
            c_quo_q     <= '0;
            c_rem_q     <= '0;
            valid_q     <= 1'b0;
            result_q    <= '0;
            rd_out_q    <= '0;
        end else begin
            valid_q <= 1'b0;
            unique case (state_q)
                S_IDLE:
                    if (accept) begin
                        f3_q        <= funct3_i;
                        rd_q        <= rd_i;
                        op1_q       <= op1_i;
                        op2_q       <= op2_i;
                        neg_q       <= n1 ^ n2;
                        rneg_q      <= n1;
                        early_q     <= fast;
                        early_res_q <= fast_res;
                        from_div_q  <= ~mul_op & ~fast;
                        mcand_q     <= mag1;
                        prod_q      <= {{XLEN{1'b0}}, mag2};
                        cnt_q       <= mul_op ? MUL_CNT : CW'(XLEN);
                    end
                S_MUL: begin
                    prod_q <= prod_nx;
                    cnt_q  <= cnt_q - 1'b1;
                end
                S_DIV:
                    cnt_q <= '0;
                S_DONE:
                    if (!flush_i) begin
                        valid_q  <= 1'b1;
                        result_q <= done_res;
                        rd_out_q <= rd_q;
                        if (from_div_q) begin
                            c_vld_q <= 1'b1;
                            c_sgn_q <= is_signed_div(f3_q);
                            c_op1_q <= op1_q;
                            c_op2_q <= op2_q;
                            c_quo_q <= qfix;
                            c_rem_q <= rfix;
                        end
                    end
            endcase
        end
    end

    assign result_o = result_q;
    assign rd_o     = rd_out_q;

endmodule
